// File: rtl/posit_mult_arbiter.sv
// Round-robin arbiter sharing one combinational posit multiplier between
// two operand sources; registers operands, captures product with ID.
module posit_mult_arbiter #(
    parameter int N  = 32,
    parameter int ES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [N-1:0] i_req0_in1,
    input  logic [N-1:0] i_req0_in2,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [N-1:0] i_req1_in1,
    input  logic [N-1:0] i_req1_in2,
    output logic [N-1:0] o_mul_in1,
    output logic [N-1:0] o_mul_in2,
    input  logic [N-1:0] i_mul_out,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [N-1:0] o_res_out,
    output logic         o_res_id,
    output logic         o_busy
);

    if (N < 3 || ES > N - 3) begin : g_bad_cfg
        $error("posit_mult_arbiter: ES too wide for N");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_HOLD
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last;
    logic         r_id;
    logic         r_arm;
    logic [N-1:0] r_mul_in1;
    logic [N-1:0] r_mul_in2;
    logic [N-1:0] r_res_out;
    logic         r_res_id;
    logic         r_res_valid;

    logic         w_grant0;
    logic         w_grant1;
    logic         w_slot;
    logic         w_acc0;
    logic         w_acc1;
    logic         w_acc;
    logic [N-1:0] w_op1;
    logic [N-1:0] w_op2;

    // r_arm keeps READY low in the cycle reset is released
    always_comb begin
        w_grant0 = i_req0_valid & (~i_req1_valid | r_last);
        w_grant1 = i_req1_valid & (~i_req0_valid | ~r_last);
        w_slot   = r_arm & ~i_rst &
                   ((r_state == S_IDLE) |
                    ((r_state == S_HOLD) & i_res_ready));
        w_acc0   = w_grant0 & w_slot;
        w_acc1   = w_grant1 & w_slot;
        w_acc    = w_acc0 | w_acc1;
        w_op1    = w_acc1 ? i_req1_in1 : i_req0_in1;
        w_op2    = w_acc1 ? i_req1_in2 : i_req0_in2;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) w_state_nxt = S_MULT;
            end
            S_MULT: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_acc)
                    w_state_nxt = S_MULT;
                else if (i_res_ready)
                    w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_arm   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_arm   <= 1'b1;
        end
    end

    // Pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mul_in1 <= '0;
            r_mul_in2 <= '0;
            r_id      <= 1'b0;
            r_last    <= 1'b1;
        end else if (w_acc) begin
            r_mul_in1 <= w_op1;
            r_mul_in2 <= w_op2;
            r_id      <= w_acc1;
            r_last    <= w_acc1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_out   <= '0;
            r_res_id    <= 1'b0;
            r_res_valid <= 1'b0;
        end else if (r_state == S_MULT) begin
            r_res_out   <= i_mul_out;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
        end else if (r_state == S_HOLD && i_res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign o_req0_ready = w_acc0;
    assign o_req1_ready = w_acc1;
    assign o_mul_in1    = r_mul_in1;
    assign o_mul_in2    = r_mul_in2;
    assign o_res_out    = r_res_out;
    assign o_res_id     = r_res_id;
    assign o_res_valid  = r_res_valid;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_posit_mult_arbiter.sv
// Scoreboard bench for posit_mult_arbiter with a behavioural
// posit<16,1> multiplier standing in for the real one.
module tb_posit_mult_arbiter;

    localparam int N  = 16;
    localparam int ES = 1;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    typedef struct packed {
        logic        id;
        logic [15:0] p;
    } exp_t;

    typedef struct packed {
        logic        id;
        logic [15:0] p;
        logic [31:0] cyc;
    } seen_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready;
    logic [N-1:0]  req0_in1, req0_in2;
    logic          req1_valid, req1_ready;
    logic [N-1:0]  req1_in1, req1_in2;
    logic [N-1:0]  mul_in1, mul_in2, mul_out;
    logic          res_valid, res_ready;
    logic [N-1:0]  res_out;
    logic          res_id;
    logic          busy;

    int            n_chk = 0;
    int            n_err = 0;
    int            n_acc = 0;
    int            n_res = 0;
    logic [31:0]   cyc = 0;
    bit            p_rand = 0;

    pair_t         src0[$];
    pair_t         src1[$];
    exp_t          sb_q[$];
    seen_t         seen_q[$];

    posit_mult_arbiter #(.N(N), .ES(ES)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_in1   (req0_in1),
        .i_req0_in2   (req0_in2),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_in1   (req1_in1),
        .i_req1_in2   (req1_in2),
        .o_mul_in1    (mul_in1),
        .o_mul_in2    (mul_in2),
        .i_mul_out    (mul_out),
        .o_res_valid  (res_valid),
        .i_res_ready  (res_ready),
        .o_res_out    (res_out),
        .o_res_id     (res_id),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Posit decode: sign, scale (2k+e) and 13-bit mantissa with hidden one
    function automatic void p_dec(input logic [15:0] x, output logic s,
                                  output int sc, output int unsigned m);
        logic [15:0] v;
        logic [14:0] r;
        int run, c, fb, k;
        int unsigned f;
        logic e;
        s = x[15];
        v = x[15] ? (~x + 16'd1) : x;
        r = v[14:0];
        run = 1;
        while (run < 15 && r[14-run] == r[14]) run++;
        k = r[14] ? run - 1 : -run;
        c = 14 - run;
        if (c >= 1) begin
            e  = r[c-1];
            fb = c - 1;
        end else begin
            e  = 1'b0;
            fb = 0;
        end
        f  = 32'(r) & ((32'd1 << fb) - 32'd1);
        m  = (32'd1 << 12) | (f << (12 - fb));
        sc = 2 * k + (e ? 1 : 0);
    endfunction

    function automatic logic [15:0] p_mul(input logic [15:0] a,
                                          input logic [15:0] b);
        logic sa, sb, s, e, g, st;
        int ea, eb, sc, k, n, sh;
        int unsigned ma, mb;
        longint unsigned prod, fr, bits, keep;
        logic [15:0] res;
        if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        p_dec(a, sa, ea, ma);
        p_dec(b, sb, eb, mb);
        s    = sa ^ sb;
        sc   = ea + eb;
        prod = 64'(ma) * 64'(mb);
        if (prod[25]) begin
            sc++;
            fr = prod & 64'h1FF_FFFF;
        end else begin
            fr = (prod << 1) & 64'h1FF_FFFF;
        end
        if (sc >= 28) begin
            keep = 64'h7FFF;
        end else if (sc < -28) begin
            keep = 64'h1;
        end else begin
            k    = sc >>> 1;
            e    = sc[0];
            bits = 0;
            n    = 0;
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) begin
                    bits = (bits << 1) | 64'd1;
                    n++;
                end
                bits = bits << 1;
                n++;
            end else begin
                for (int i = 0; i < -k; i++) begin
                    bits = bits << 1;
                    n++;
                end
                bits = (bits << 1) | 64'd1;
                n++;
            end
            bits = (bits << 1) | 64'(e);
            n++;
            bits = (bits << 25) | fr;
            n += 25;
            sh   = n - 15;
            keep = bits >> sh;
            g    = bits[sh-1];
            st   = (bits & ((64'd1 << (sh - 1)) - 64'd1)) != 0;
            if (g && (st || keep[0])) keep++;
        end
        res = {1'b0, keep[14:0]};
        return s ? (~res + 16'd1) : res;
    endfunction

    always_comb mul_out = p_mul(mul_in1, mul_in2);

    function automatic logic [15:0] rnd_op();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 7))
            0: x = 16'h0000;
            1: x = 16'h8000;
            default: ;
        endcase
        return x;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester driver: holds VALID and operands until accepted
    initial begin
        bit a0, a1;
        pair_t pr;
        req0_valid = 0; req0_in1 = 0; req0_in2 = 0;
        req1_valid = 0; req1_in1 = 0; req1_in2 = 0;
        forever begin
            @(negedge clk);
            a0 = req0_valid && req0_ready && !rst;
            a1 = req1_valid && req1_ready && !rst;
            @(posedge clk);
            #1;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            if (!req0_valid) begin
                if (src0.size() != 0) begin
                    pr = src0.pop_front();
                    req0_in1 = pr.a; req0_in2 = pr.b; req0_valid = 1'b1;
                end else if (p_rand && $urandom_range(0, 2) != 0) begin
                    req0_in1 = rnd_op(); req0_in2 = rnd_op();
                    req0_valid = 1'b1;
                end
            end
            if (!req1_valid) begin
                if (src1.size() != 0) begin
                    pr = src1.pop_front();
                    req1_in1 = pr.a; req1_in2 = pr.b; req1_valid = 1'b1;
                end else if (p_rand && $urandom_range(0, 2) != 0) begin
                    req1_in1 = rnd_op(); req1_in2 = rnd_op();
                    req1_valid = 1'b1;
                end
            end
        end
    end

    // Reference model: round-robin over valid requests, one product
    // in flight, result pending until the consumer takes it
    initial begin
        int m_stage;
        bit m_last, m_block, any, g, slot, e0, e1;
        logic [15:0] m_op1, m_op2;
        int m_wait[2];
        m_stage = 0; m_last = 1; m_block = 1;
        m_op1 = 0; m_op2 = 0; m_wait[0] = 0; m_wait[1] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_stage = 0; m_last = 1; m_block = 1;
                m_wait[0] = 0; m_wait[1] = 0;
                sb_q.delete();
            end else begin
                any  = req0_valid || req1_valid;
                g    = (req0_valid && req1_valid) ? !m_last : !req0_valid;
                slot = !m_block &&
                       (m_stage == 0 || (m_stage == 2 && res_ready));
                e0   = slot && any && !g;
                e1   = slot && any && g;
                chk("ready0", 32'(req0_ready), 32'(e0));
                chk("ready1", 32'(req1_ready), 32'(e1));
                chk("res_valid", 32'(res_valid), 32'(m_stage == 2));
                chk("busy", 32'(busy), 32'(m_stage != 0));
                if (m_stage == 1) begin
                    chk("mul_in1", 32'(mul_in1), 32'(m_op1));
                    chk("mul_in2", 32'(mul_in2), 32'(m_op2));
                end
                if (e0 || e1) begin
                    m_op1 = g ? req1_in1 : req0_in1;
                    m_op2 = g ? req1_in2 : req0_in2;
                    sb_q.push_back('{id: g, p: p_mul(m_op1, m_op2)});
                    n_acc++;
                    if (g ? req0_valid : req1_valid) begin
                        m_wait[!g] = m_wait[!g] + 1;
                        chk("starve", 32'(m_wait[!g] <= 1), 32'd1);
                    end
                    m_wait[g] = 0;
                    m_last  = g;
                    m_stage = 1;
                end else if (m_stage == 1) begin
                    m_stage = 2;
                end else if (m_stage == 2 && res_ready) begin
                    m_stage = 0;
                end
                m_block = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each result handshake
    initial begin
        bit p_valid, p_ready, p_id;
        logic [15:0] p_out;
        exp_t ex;
        p_valid = 0; p_ready = 0; p_id = 0; p_out = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_valid = 0;
            end else begin
                if (p_valid && !p_ready) begin
                    chk("hold_valid", 32'(res_valid), 32'd1);
                    chk("hold_out", 32'(res_out), 32'(p_out));
                    chk("hold_id", 32'(res_id), 32'(p_id));
                end
                if (res_valid && res_ready) begin
                    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        ex = sb_q.pop_front();
                        chk("res_out", 32'(res_out), 32'(ex.p));
                        chk("res_id", 32'(res_id), 32'(ex.id));
                    end
                    n_res++;
                    seen_q.push_back('{id: res_id, p: res_out, cyc: cyc});
                end
                p_valid = res_valid;
                p_ready = res_ready;
                p_out   = res_out;
                p_id    = res_id;
            end
        end
    end

    task automatic wait_ready(input bit x, input string nm);
        int t;
        bit ok;
        t = 0; ok = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            t++;
            ok = x ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
        end
        chk(nm, 32'(ok), 32'd1);
    endtask

    task automatic wait_results(input int n, input string nm);
        int t;
        t = 0;
        while (seen_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 32'(seen_q.size() >= n), 32'd1);
    endtask

    task automatic wait_res_valid(input string nm);
        int t;
        t = 0;
        while (!res_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 32'(res_valid), 32'd1);
    endtask

    task automatic rst_off();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] saved;
        int t, a0, r0;
        rst = 1'b1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req0_ready | req1_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_out", 32'(res_out), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul", 32'({mul_in1, mul_in2}), 32'd0);

        // single requester, 2.0 x 2.0
        res_ready = 1'b1;
        src0.push_back('{a: 16'h5000, b: 16'h5000});
        rst_off();
        wait_ready(1'b0, "t1_ready");
        @(negedge clk);
        chk("t1_mult", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(res_valid), 32'd1);
        chk("t1_out", 32'(res_out), 32'h6000);
        chk("t1_id", 32'(res_id), 32'd0);
        repeat (3) @(negedge clk);

        // both valid from reset: alternate 0,1,0
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen_q.delete();
        src0.push_back('{a: 16'h4800, b: 16'h5000});
        src0.push_back('{a: 16'h4800, b: 16'h5000});
        src1.push_back('{a: 16'h5000, b: 16'h5000});
        rst_off();
        wait_results(3, "t2_done");
        if (seen_q.size() >= 3) begin
            chk("t2_r0_out", 32'(seen_q[0].p), 32'h5800);
            chk("t2_r0_id", 32'(seen_q[0].id), 32'd0);
            chk("t2_r1_out", 32'(seen_q[1].p), 32'h6000);
            chk("t2_r1_id", 32'(seen_q[1].id), 32'd1);
            chk("t2_gap", seen_q[1].cyc - seen_q[0].cyc, 32'd2);
            chk("t2_r2_id", 32'(seen_q[2].id), 32'd0);
        end

        // consumer stall with both requesters waiting
        repeat (3) @(negedge clk);
        seen_q.delete();
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        src0.push_back('{a: 16'h4000, b: 16'h4000});
        src0.push_back('{a: 16'h5800, b: 16'h4800});
        src1.push_back('{a: 16'h3000, b: 16'h6000});
        src1.push_back('{a: 16'hC000, b: 16'h5000});
        wait_res_valid("t3_valid");
        saved = res_out;
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_rdy", 32'(req0_ready | req1_ready), 32'd0);
            chk("t3_stall_out", 32'(res_out), 32'(saved));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        chk("t3_same_cyc", 32'(req0_ready | req1_ready), 32'd1);
        chk("t3_hs_valid", 32'(res_valid), 32'd1);
        wait_results(4, "t3_done");

        // NaR and zero pass through
        repeat (3) @(negedge clk);
        seen_q.delete();
        src1.push_back('{a: 16'h8000, b: 16'h4000});
        wait_results(1, "t4_nar_done");
        if (seen_q.size() >= 1) begin
            chk("t4_nar", 32'(seen_q[0].p), 32'h8000);
            chk("t4_nar_id", 32'(seen_q[0].id), 32'd1);
        end
        src0.push_back('{a: 16'h0000, b: 16'h6000});
        wait_results(2, "t4_zero_done");
        if (seen_q.size() >= 2) begin
            chk("t4_zero", 32'(seen_q[1].p), 32'h0000);
            chk("t4_zero_id", 32'(seen_q[1].id), 32'd0);
        end

        // reset during MULT, then during HOLD
        repeat (3) @(negedge clk);
        src0.push_back('{a: 16'h5000, b: 16'h5000});
        wait_ready(1'b0, "t5_ready");
        @(posedge clk);
        #1;
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5m_busy", 32'(busy), 32'd0);
        chk("t5m_mul", 32'({mul_in1, mul_in2}), 32'd0);
        chk("t5m_valid", 32'(res_valid), 32'd0);
        rst_off();
        res_ready = 1'b0;
        src0.push_back('{a: 16'h5000, b: 16'h4000});
        wait_res_valid("t5_hold");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t5h_valid", 32'(res_valid), 32'd0);
        chk("t5h_out", 32'(res_out), 32'd0);
        chk("t5h_id", 32'(res_id), 32'd0);
        chk("t5h_ready", 32'(req0_ready | req1_ready), 32'd0);
        res_ready = 1'b1;
        src0.push_back('{a: 16'h4800, b: 16'h4800});
        src1.push_back('{a: 16'h5000, b: 16'h5000});
        rst_off();
        t = 0;
        while (!(req0_ready || req1_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("t5_tie_r0", 32'(req0_ready), 32'd1);
        chk("t5_tie_r1", 32'(req1_ready), 32'd0);
        repeat (10) @(negedge clk);

        // random traffic
        a0 = n_acc;
        r0 = n_res;
        p_rand = 1;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk);
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
        end
        p_rand = 0;
        res_ready = 1'b1;
        t = 0;
        while ((sb_q.size() != 0 || req0_valid || req1_valid || busy)
               && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("t6_drain", 32'(sb_q.size()), 32'd0);
        chk("t6_count", 32'(n_res - r0), 32'(n_acc - a0));
        chk("t6_activity", 32'(n_acc - a0 > 1000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
